alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath ALU.
- Adds an internal iterative unsigned multiplier and divider with owned HI/LO registers, shifts, and start/ready/valid sequencing.
- Sits between the register-file read stage and the write-back stage; the control FSM issues one operation per handshake and waits for valid.

Parameters:
WIDTH, 16, operand/result width in bits; legal values 4..64.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only on a cycle where ready=1
codop  input  4  operation code, sampled with start
operando1  input  WIDTH  first operand, sampled with start
operando2  input  WIDTH  second operand, sampled with start
ready  output  1  block idle, can accept start
valid  output  1  one-cycle pulse: resultado and flags are updated this cycle
resultado  output  WIDTH  registered result, held until the next valid
neg  output  1  resultado[WIDTH-1], updated with valid
zero  output  1  resultado==0, updated with valid
overflow  output  1  signed overflow (ADD/SUB/RSUB) or divide-by-zero (DIVU); else 0

Behaviour:
- Reset (async, rst_n=0): state IDLE, ready=1, valid=0, resultado=0, neg=0, zero=0, overflow=0, HI=0, LO=0, counter=0. Reset mid-MUL/DIV aborts the operation; no valid is produced and HI/LO read 0.
- Opcodes (mod 2^WIDTH arithmetic):
  - 0 ADD: op1+op2.
  - 1 SUB: op1-op2.
  - 2 SGTU: 1 if op1>op2 unsigned, else 0.
  - 3 AND; 4 OR; 5 XOR; 8 NOR.
  - 6 MULU; 7 DIVU (see below).
  - 9 SLL: op1<<op2. 15 SRL: op1>>op2 logical. If op2>=WIDTH, result=0.
  - 10 RSUB: op2-op1.
  - 11 PASS: op1.
  - 12 MOVZ: if op1==0, result=op2; else result=previous resultado, unchanged.
  - 13 MFHI: HI.
  - 14 MFLO: LO.
- Overflow rules:
  - ADD: sign(a)==sign(b) and sign(result)!=sign(a).
  - SUB: a=op1, b=op2; overflow when sign(a)!=sign(b) and sign(result)!=sign(a).
  - RSUB: same as SUB with a=op2, b=op1.
- FSM states: IDLE, MUL, DIV.
  - IDLE, start=1, single-cycle op: result registered at that edge; valid=1 the following cycle (latency 1); stays in IDLE with ready=1, so back-to-back starts give back-to-back valids.
  - IDLE, start=1, codop 6: latch operands, clear accumulator, counter=0, go to MUL, ready=0.
    - Shift-add, one multiplier bit per cycle, WIDTH iterations.
    - On the final iteration: {HI,LO}=op1*op2 (2*WIDTH bits), resultado=LO, valid=1, return to IDLE.
    - Latency from accepting edge to valid: WIDTH+1 cycles.
  - IDLE, start=1, codop 7: go to DIV; restoring division, one quotient bit per cycle, WIDTH iterations; on completion LO=quotient, HI=remainder, resultado=LO, valid=1, latency WIDTH+1.
    - op2==0: no iteration; next cycle LO=all ones, HI=op1, resultado=all ones, overflow=1, valid=1 (latency 1).
- start while ready=0 is ignored: operands and codop are not captured, and no extra valid is produced.
- HI/LO change only on MUL/DIV completion. MFHI/MFLO issued in the cycle after a MUL/DIV valid return the new values.
- neg/zero/overflow update only on valid and hold otherwise. overflow=0 for every op other than ADD/SUB/RSUB/DIVU-by-zero.
- valid is never high for two cycles from a single accepted start.

Test Plan:
- WIDTH=16, ADD 0x7FFF+0x0001 -> valid one cycle after start, resultado=0x8000, neg=1, overflow=1, zero=0; SUB 0x0005-0x0005 -> resultado=0, zero=1, overflow=0.
- MULU 0x1234*0x0100 -> ready low 16 cycles, valid at cycle 17, resultado=0x3400; then MFHI -> 0x0012, MFLO -> 0x3400.
- DIVU 100/7 -> valid at cycle 17, resultado=14; MFHI -> 2. DIVU 0x00AB/0 -> valid next cycle, resultado=0xFFFF, overflow=1; MFHI -> 0x00AB.
- SLL 0x0001 by 15 -> 0x8000; SLL by 16 -> 0x0000, zero=1; SRL 0x8000 by 3 -> 0x1000. MOVZ op1=0, op2=0x55AA -> 0x55AA; MOVZ op1=1 -> resultado unchanged (0x55AA).
- Start MULU, pulse start with ADD at cycle 5 while busy -> ADD ignored, exactly one valid, with the MUL result.
- Assert rst_n=0 at cycle 8 of a MULU -> immediately ready=1, resultado=0, flags=0, no valid; MFHI afterwards -> 0.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU with iterative shift-add multiplier and restoring divider.
// HI/LO hold the full product or the remainder/quotient of the last MULU/DIVU.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       codop,
  input  logic [WIDTH-1:0] operando1,
  input  logic [WIDTH-1:0] operando2,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] resultado,
  output logic             neg,
  output logic             zero,
  output logic             overflow
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SGTU = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MULU = 4'd6;
  localparam logic [3:0] OP_DIVU = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_RSUB = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;
  localparam logic [3:0] OP_MOVZ = 4'd12;
  localparam logic [3:0] OP_MFHI = 4'd13;
  localparam logic [3:0] OP_MFLO = 4'd14;
  localparam logic [3:0] OP_SRL  = 4'd15;

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] LP_WIDTH = (WIDTH + 1)'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_res, r_hi, r_lo;
  logic [WIDTH-1:0] r_acc, r_mq, r_opb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid, r_neg, r_zero, r_ovf;

  logic             w_ready, w_accept, w_done, w_iter_last;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH-1:0] w_add, w_sub, w_rsub;
  logic             w_shamt_big;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub, w_div_rem, w_div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Divide-by-zero completes at the accepting edge, so it never leaves IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_iter_last = (r_cnt == CNT_W'(WIDTH - 1));
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          if (codop == OP_MULU)
            w_state_nxt = S_MUL;
          else if (codop == OP_DIVU && operando2 != '0)
            w_state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (w_iter_last) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One iteration step each for the multiplier {r_acc,r_mq} and divider {r_acc=rem, r_mq=dividend/quotient}.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opb} : '0);
    w_mul_hi    = w_mul_sum[WIDTH:1];
    w_mul_lo    = {w_mul_sum[0], r_mq[WIDTH-1:1]};
    w_div_shift = {r_acc, r_mq[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_opb;
    w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
    w_div_q     = {r_mq[WIDTH-2:0], w_div_ge};
  end

  always_comb begin
    w_add       = operando1 + operando2;
    w_sub       = operando1 - operando2;
    w_rsub      = operando2 - operando1;
    w_shamt_big = ({1'b0, operando2} >= LP_WIDTH);
    w_res       = r_res;
    w_ovf       = 1'b0;
    unique case (codop)
      OP_ADD: begin
        w_res = w_add;
        w_ovf = (operando1[MSB] == operando2[MSB]) && (w_add[MSB] != operando1[MSB]);
      end
      OP_SUB: begin
        w_res = w_sub;
        w_ovf = (operando1[MSB] != operando2[MSB]) && (w_sub[MSB] != operando1[MSB]);
      end
      OP_RSUB: begin
        w_res = w_rsub;
        w_ovf = (operando2[MSB] != operando1[MSB]) && (w_rsub[MSB] != operando2[MSB]);
      end
      OP_SGTU: w_res = {{(WIDTH-1){1'b0}}, (operando1 > operando2)};
      OP_AND:  w_res = operando1 & operando2;
      OP_OR:   w_res = operando1 | operando2;
      OP_XOR:  w_res = operando1 ^ operando2;
      OP_NOR:  w_res = ~(operando1 | operando2);
      OP_SLL:  w_res = w_shamt_big ? '0 : (operando1 << operando2);
      OP_SRL:  w_res = w_shamt_big ? '0 : (operando1 >> operando2);
      OP_PASS: w_res = operando1;
      OP_MOVZ: if (operando1 == '0) w_res = operando2;
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
      default: w_res = r_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_opb   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_neg   <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        if (codop == OP_MULU) begin
          r_acc <= '0;
          r_mq  <= operando2;
          r_opb <= operando1;
          r_cnt <= '0;
        end else if (codop == OP_DIVU) begin
          if (operando2 == '0) begin
            r_lo    <= '1;
            r_hi    <= operando1;
            r_res   <= '1;
            r_neg   <= 1'b1;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_acc <= '0;
            r_mq  <= operando1;
            r_opb <= operando2;
            r_cnt <= '0;
          end
        end else begin
          r_res   <= w_res;
          r_neg   <= w_res[MSB];
          r_zero  <= (w_res == '0);
          r_ovf   <= w_ovf;
          r_valid <= 1'b1;
        end
      end else if (r_state == S_MUL) begin
        r_acc <= w_mul_hi;
        r_mq  <= w_mul_lo;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_done) begin
          r_hi    <= w_mul_hi;
          r_lo    <= w_mul_lo;
          r_res   <= w_mul_lo;
          r_neg   <= w_mul_lo[MSB];
          r_zero  <= (w_mul_lo == '0);
          r_ovf   <= 1'b0;
          r_valid <= 1'b1;
        end
      end else if (r_state == S_DIV) begin
        r_acc <= w_div_rem;
        r_mq  <= w_div_q;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_done) begin
          r_hi    <= w_div_rem;
          r_lo    <= w_div_q;
          r_res   <= w_div_q;
          r_neg   <= w_div_q[MSB];
          r_zero  <= (w_div_q == '0);
          r_ovf   <= 1'b0;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign ready     = w_ready;
  assign valid     = r_valid;
  assign resultado = r_res;
  assign neg       = r_neg;
  assign zero      = r_zero;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues expected results, a negedge monitor pops and compares them.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  codop;
  logic [15:0] operando1, operando2;
  logic        ready, valid, neg, zero, overflow;
  logic [15:0] resultado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [15:0] res;
    logic        n, z, o;
  } exp_t;

  exp_t sb_q[$];

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .codop(codop),
    .operando1(operando1), .operando2(operando2),
    .ready(ready), .valid(valid), .resultado(resultado),
    .neg(neg), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input logic [15:0] r, input logic n, z, o);
    exp_t e;
    e.nm = nm; e.res = r; e.n = n; e.z = z; e.o = o;
    sb_q.push_back(e);
  endtask

  // Waits for valid after the accepting edge; checks latency and busy (ready low) cycles.
  task automatic wait_valid(input string nm, input int lat);
    int cyc;
    int busy;
    cyc  = 1;
    busy = 0;
    while (!valid && cyc < 40) begin
      if (!ready) busy++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, ".lat"}, cyc, lat);
    chk({nm, ".busy"}, busy, lat - 1);
  endtask

  // Called at posedge+1 with the DUT idle.
  task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] a, b,
                       input logic [15:0] er, input logic en, ez, eo, input int lat);
    push_exp(nm, er, en, ez, eo);
    start = 1'b1; codop = op; operando1 = a; operando2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(nm, lat);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got resultado=%h expected no valid", resultado);
        end else begin
          e = sb_q.pop_front();
          chk({e.nm, ".res"}, resultado, e.res);
          chk({e.nm, ".neg"}, neg, e.n);
          chk({e.nm, ".zero"}, zero, e.z);
          chk({e.nm, ".ovf"}, overflow, e.o);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst_n = 1'b0; start = 1'b0; codop = '0; operando1 = '0; operando2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", ready, 1);
    chk("rst.valid", valid, 0);
    chk("rst.res", resultado, 0);
    chk("rst.flags", {neg, zero, overflow}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("add_ovf",  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1, 0, 1, 1);
    issue("sub_zero", 4'd1,  16'h0005, 16'h0005, 16'h0000, 0, 1, 0, 1);
    issue("add_plain",4'd0,  16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 1);
    issue("sub_ovf",  4'd1,  16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1, 1);
    issue("rsub_ovf", 4'd10, 16'h0001, 16'h8000, 16'h7FFF, 0, 0, 1, 1);
    issue("sgtu",     4'd2,  16'h0005, 16'h0003, 16'h0001, 0, 0, 0, 1);
    issue("sgtu_eq",  4'd2,  16'h0003, 16'h0003, 16'h0000, 0, 1, 0, 1);
    issue("and",      4'd3,  16'hFF00, 16'h0FF0, 16'h0F00, 0, 0, 0, 1);
    issue("or",       4'd4,  16'hFF00, 16'h0FF0, 16'hFFF0, 1, 0, 0, 1);
    issue("xor",      4'd5,  16'hFF00, 16'h0FF0, 16'hF0F0, 1, 0, 0, 1);
    issue("nor",      4'd8,  16'h00FF, 16'h0F00, 16'hF000, 1, 0, 0, 1);
    issue("pass",     4'd11, 16'h1234, 16'hFFFF, 16'h1234, 0, 0, 0, 1);

    issue("mulu",     4'd6,  16'h1234, 16'h0100, 16'h3400, 0, 0, 0, 17);
    issue("mfhi_mul", 4'd13, 16'h0000, 16'h0000, 16'h0012, 0, 0, 0, 1);
    issue("mflo_mul", 4'd14, 16'h0000, 16'h0000, 16'h3400, 0, 0, 0, 1);

    issue("divu",     4'd7,  16'd100,  16'd7,    16'd14,   0, 0, 0, 17);
    issue("mfhi_div", 4'd13, 16'h0000, 16'h0000, 16'd2,    0, 0, 0, 1);
    issue("div0",     4'd7,  16'h00AB, 16'h0000, 16'hFFFF, 1, 0, 1, 1);
    issue("mfhi_d0",  4'd13, 16'h0000, 16'h0000, 16'h00AB, 0, 0, 0, 1);
    issue("mflo_d0",  4'd14, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 0, 1);

    issue("sll15",    4'd9,  16'h0001, 16'd15,   16'h8000, 1, 0, 0, 1);
    issue("sll16",    4'd9,  16'h0001, 16'd16,   16'h0000, 0, 1, 0, 1);
    issue("srl3",     4'd15, 16'h8000, 16'd3,    16'h1000, 0, 0, 0, 1);
    issue("srl_big",  4'd15, 16'h8000, 16'hFFFF, 16'h0000, 0, 1, 0, 1);
    issue("movz_take",4'd12, 16'h0000, 16'h55AA, 16'h55AA, 0, 0, 0, 1);
    issue("movz_keep",4'd12, 16'h0001, 16'h1234, 16'h55AA, 0, 0, 0, 1);

    // A start while busy must be ignored entirely.
    push_exp("mul_busy", 16'h000F, 0, 0, 0);
    start = 1'b1; codop = 4'd6; operando1 = 16'h0003; operando2 = 16'h0005;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; codop = 4'd0; operando1 = 16'h1111; operando2 = 16'h2222;
    chk("busy.ready", ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid("mul_busy", 12);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a multiply aborts it.
    start = 1'b1; codop = 4'd6; operando1 = 16'h1234; operando2 = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("abort.busy", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort.ready", ready, 1);
    chk("abort.valid", valid, 0);
    chk("abort.res", resultado, 0);
    chk("abort.flags", {neg, zero, overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    issue("mfhi_rst", 4'd13, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1);
    issue("mflo_rst", 4'd14, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
